// File: rtl/pc_seq_pkg.sv
// Shared definitions for the MSP430 PC sequencer: PC mux select codes, FSM states
// and the extension-count clamp.
package pc_seq_pkg;

  // mux_pc select codes; mux_pc decodes the same values
  localparam logic [2:0] MPC_HOLD = 3'd0;
  localparam logic [2:0] MPC_INC2 = 3'd1;
  localparam logic [2:0] MPC_MDB  = 3'd2;
  localparam logic [2:0] MPC_CALC = 3'd3;

  typedef enum logic [2:0] {
    S_RST   = 3'd0,
    S_VEC   = 3'd1,
    S_FETCH = 3'd2,
    S_DEC   = 3'd3,
    S_EXT   = 3'd4,
    S_EXEC  = 3'd5,
    S_IRQ   = 3'd6
  } state_t;

  function automatic logic [1:0] clamp_ext(input logic [1:0] n_ext, input logic [1:0] max_ext);
    return (n_ext > max_ext) ? max_ext : n_ext;
  endfunction

endpackage

// File: rtl/pc_seq.sv
// Program-counter sequencer driving mux_pc through the MSP430 fetch flow.
// Define PC_SEQ_WAIT_EN to honour MDB_VALID (wait-state memory); otherwise reads complete in one cycle.
module pc_seq
  import pc_seq_pkg::*;
#(
  parameter logic [15:0] RESET_VEC    = 16'hFFFE,
  parameter logic [15:0] IRQ_VEC_BASE = 16'hFFE0,
  parameter int          MAX_EXT      = 2
) (
  input  logic        MCLK,
  input  logic        RST_N,
  input  logic        MDB_VALID,
  input  logic        DEC_VALID,
  input  logic [1:0]  N_EXT,
  input  logic        EXEC_DONE,
  input  logic        JMP_TAKEN,
  input  logic        PC_LOAD_MDB,
  input  logic        IRQ_PEND,
  input  logic [3:0]  IRQ_NUM,
  output logic [2:0]  MPC,
  output logic        MEM_RD,
  output logic        VEC_SEL,
  output logic [15:0] VEC_ADDR,
  output logic        IR_LOAD,
  output logic        EXT_LOAD,
  output logic [1:0]  EXT_IDX,
  output logic        IRQ_ACK
);

  localparam logic [1:0] MAX_EXT_L = 2'(MAX_EXT);

  state_t     state_q, state_d;
  logic [1:0] ext_cnt_q, ext_cnt_d;
  logic [1:0] n_ext_q, n_ext_d;
  logic       irq_ack_q, irq_ack_d;
  logic       mdb_ok;
  logic [1:0] n_ext_clamped;
  logic [15:0] irq_vec;

`ifdef PC_SEQ_WAIT_EN
  assign mdb_ok = MDB_VALID;
`else
  logic unused_mdb_valid;
  assign unused_mdb_valid = MDB_VALID;
  assign mdb_ok = 1'b1;
`endif

  assign n_ext_clamped = clamp_ext(N_EXT, MAX_EXT_L);
  assign irq_vec       = 16'(IRQ_VEC_BASE + {11'd0, IRQ_NUM, 1'b0});
  assign IRQ_ACK       = irq_ack_q;

  always_ff @(posedge MCLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_RST;
      ext_cnt_q <= 2'd0;
      n_ext_q   <= 2'd0;
      irq_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ext_cnt_q <= ext_cnt_d;
      n_ext_q   <= n_ext_d;
      irq_ack_q <= irq_ack_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ext_cnt_d = ext_cnt_q;
    n_ext_d   = n_ext_q;
    irq_ack_d = 1'b0;
    MPC       = MPC_HOLD;
    MEM_RD    = 1'b0;
    VEC_SEL   = 1'b0;
    VEC_ADDR  = 16'd0;
    IR_LOAD   = 1'b0;
    EXT_LOAD  = 1'b0;
    EXT_IDX   = 2'd0;

    unique case (state_q)
      S_RST: begin
        MEM_RD   = 1'b1;
        VEC_SEL  = 1'b1;
        VEC_ADDR = RESET_VEC;
        state_d  = S_VEC;
      end
      S_VEC: begin
        MEM_RD   = 1'b1;
        VEC_SEL  = 1'b1;
        VEC_ADDR = RESET_VEC;
        if (mdb_ok) begin
          MPC     = MPC_MDB;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        MEM_RD = 1'b1;
        if (mdb_ok) begin
          IR_LOAD = 1'b1;
          MPC     = MPC_INC2;
          state_d = S_DEC;
        end
      end
      S_DEC: begin
        if (DEC_VALID) begin
          n_ext_d   = n_ext_clamped;
          ext_cnt_d = 2'd0;
          state_d   = (n_ext_clamped == 2'd0) ? S_EXEC : S_EXT;
        end
      end
      S_EXT: begin
        MEM_RD  = 1'b1;
        EXT_IDX = ext_cnt_q;
        if (mdb_ok) begin
          EXT_LOAD  = 1'b1;
          MPC       = MPC_INC2;
          ext_cnt_d = ext_cnt_q + 2'd1;
          if (ext_cnt_d == n_ext_q) state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (EXEC_DONE) begin
          // a taken jump outranks a PC load from the data bus
          if (JMP_TAKEN)        MPC = MPC_CALC;
          else if (PC_LOAD_MDB) MPC = MPC_MDB;
          irq_ack_d = IRQ_PEND;
          state_d   = IRQ_PEND ? S_IRQ : S_FETCH;
        end
      end
      S_IRQ: begin
        MEM_RD   = 1'b1;
        VEC_SEL  = 1'b1;
        VEC_ADDR = irq_vec;
        if (mdb_ok) begin
          MPC     = MPC_MDB;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_RST;
    endcase

    // outputs drop the instant reset asserts, even mid-cycle
    if (!RST_N) begin
      MPC      = MPC_HOLD;
      MEM_RD   = 1'b0;
      VEC_SEL  = 1'b0;
      VEC_ADDR = 16'd0;
      IR_LOAD  = 1'b0;
      EXT_LOAD = 1'b0;
      EXT_IDX  = 2'd0;
    end
  end

endmodule
